dma_dev_port: RTL

- Device-side initiator for the DMA controller's device handshake (rqst/rd_wr/num_words/start_addr, dev_ack/dma_ack, dev_in/dev_out, end_flag).
- Owns a local word buffer, issues one DMA request per command, and either fills the buffer from memory (read) or streams the buffer to memory (write).
- Provides a watchdog and command/status to the peripheral logic that instantiates it.

---
 rtl/dma_dev_port.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dma_dev_port.sv
// dma_dev_port: device-side initiator for the DMA controller handshake.
// Owns a local word buffer. One command produces one DMA request; the
// buffer is then filled from memory (read) or streamed to memory (write).
// A watchdog aborts transfers that stall without dma_ack or end_flag.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_start/rd_wr/      command strobe (IDLE only), direction
//   cmd_words/cmd_addr    (1=read into buffer), word count, byte address
//   dev_stall             local back-pressure, forces dev_ack low
//   buf_addr/wdata/we     local buffer port (writes only while idle)
//   buf_rdata             combinational buffer[buf_addr]
//   rqst/rd_wr/num_words/ DMA request side; command fields held stable
//   start_addr            for the whole transfer
//   dev_ack/dev_in        device ready/valid strobe and write data to DMA
//   dma_ack/dev_out/      DMA strobe, read data from DMA, end of transfer
//   end_flag
//   busy/done/err/        status: in progress, completion pulse, sticky
//   words_done            error, words moved by the last command
module dma_dev_port #(
  parameter int ADD_LEN   = 16,
  parameter int DATA_LEN  = 16,
  parameter int BUF_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_start,
  input  logic                 cmd_rd_wr,
  input  logic [ADD_LEN-1:0]   cmd_words,
  input  logic [ADD_LEN:0]     cmd_addr,
  input  logic                 dev_stall,
  input  logic [BUF_DEPTH-1:0] buf_addr,
  input  logic [DATA_LEN-1:0]  buf_wdata,
  input  logic                 buf_we,
  output logic [DATA_LEN-1:0]  buf_rdata,
  output logic                 rqst,
  output logic                 rd_wr,
  output logic [ADD_LEN-1:0]   num_words,
  output logic [ADD_LEN:0]     start_addr,
  output logic                 dev_ack,
  output logic [DATA_LEN-1:0]  dev_in,
  input  logic                 dma_ack,
  input  logic [DATA_LEN-1:0]  dev_out,
  input  logic                 end_flag,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BUF_DEPTH:0]   words_done
);

  localparam int IDX_W  = BUF_DEPTH + 1;
  localparam int NWORDS = 1 << BUF_DEPTH;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_XFER, S_WAIT_END, S_DONE, S_ERR
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     index_reg, index_next;
  logic [WD_W-1:0]      wdog_reg, wdog_next;
  logic                 err_next;
  logic [DATA_LEN-1:0]  mem [NWORDS];

  logic [ADD_LEN-1:0]   idx_ext;
  logic                 idx_lt, idx_last, cmd_bad, quiet, wd_hit, take_word;

  assign idx_ext   = ADD_LEN'(index_reg);
  assign idx_lt    = idx_ext < num_words;
  assign idx_last  = (idx_ext + ADD_LEN'(1)) == num_words;
  assign cmd_bad   = (cmd_words > ADD_LEN'(NWORDS)) || cmd_addr[0];
  assign quiet     = !dma_ack && !end_flag;
  // Terminal count of the watchdog; TIMEOUT=0 never hits.
  assign wd_hit    = (TIMEOUT != 0) && (wdog_reg == WD_W'(TIMEOUT - 1));
  // A DMA strobe that actually moves a word (never past num_words).
  assign take_word = (state_reg == S_XFER) && dma_ack && idx_lt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:     if (cmd_start) state_next = cmd_bad ? S_DONE : S_REQ;
      S_REQ:      state_next = S_XFER;
      S_XFER: begin
        // end_flag wins; a word strobed in the same cycle is still taken.
        if (end_flag)                                state_next = S_DONE;
        else if (!idx_lt || (dma_ack && idx_last))   state_next = S_WAIT_END;
        else if (quiet && wd_hit)                    state_next = S_ERR;
      end
      S_WAIT_END: begin
        if (end_flag)             state_next = S_DONE;
        else if (quiet && wd_hit) state_next = S_ERR;
      end
      S_DONE:     state_next = S_IDLE;
      S_ERR:      if (end_flag || wd_hit) state_next = S_DONE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Datapath next values: index, watchdog, sticky error
  always_comb begin
    index_next = index_reg;
    if (state_reg == S_IDLE && cmd_start) index_next = '0;
    else if (take_word)                   index_next = index_reg + IDX_W'(1);

    wdog_next = '0;
    unique case (state_reg)
      S_XFER, S_WAIT_END: begin
        wdog_next = quiet ? wdog_reg + WD_W'(1) : '0;
        if (state_next == S_ERR) wdog_next = '0;   // ERR gets a fresh window
      end
      S_ERR:   wdog_next = wdog_reg + WD_W'(1);
      default: wdog_next = '0;
    endcase

    err_next = err;
    if (state_reg == S_IDLE && cmd_start) err_next = cmd_bad;
    // Read data offered after the buffer slot count is exhausted is dropped.
    if ((state_reg == S_XFER || state_reg == S_WAIT_END) && dma_ack && rd_wr && !take_word)
      err_next = 1'b1;
    if (state_next == S_ERR) err_next = 1'b1;
    // Early end_flag: the DMA stopped short of the requested count.
    if (state_next == S_DONE && state_reg != S_IDLE && state_reg != S_DONE &&
        ADD_LEN'(index_next) != num_words)
      err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_reg  <= '0;
      wdog_reg   <= '0;
      err        <= 1'b0;
      words_done <= '0;
      rd_wr      <= 1'b0;
      num_words  <= '0;
      start_addr <= '0;
    end else begin
      index_reg <= index_next;
      wdog_reg  <= wdog_next;
      err       <= err_next;
      if (state_reg == S_IDLE && cmd_start && !cmd_bad) begin
        rd_wr      <= cmd_rd_wr;
        num_words  <= cmd_words;
        start_addr <= cmd_addr;
      end
      // Captured on entry so it is valid alongside the done pulse.
      if (state_next == S_DONE && state_reg != S_DONE)
        words_done <= index_next;
    end
  end

  // Buffer: not reset. Local writes are only possible while idle, so they
  // can never collide with DMA read data.
  always_ff @(posedge clk) begin
    if (take_word && rd_wr)
      mem[index_reg[BUF_DEPTH-1:0]] <= dev_out;
    else if (state_reg == S_IDLE && buf_we)
      mem[buf_addr] <= buf_wdata;
  end

  assign buf_rdata = mem[buf_addr];

  // Output logic
  always_comb begin
    rqst    = 1'b0;
    dev_ack = 1'b0;
    dev_in  = '0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_reg)
      S_IDLE: busy = 1'b0;
      S_REQ:  rqst = 1'b1;
      S_XFER: begin
        dev_ack = !dev_stall && idx_lt;
        if (!rd_wr) dev_in = mem[index_reg[BUF_DEPTH-1:0]];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
